// File: rtl/spi_ctrl_pkg.sv
// rtl/spi_ctrl_pkg.sv - shared types, defaults and timer sizing for the SPI TX sequencer
package spi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  localparam int DEF_DATA_W         = 8;
  localparam int DEF_COUNT_MAX      = 255;
  localparam int DEF_GAP_CYCLES     = 100;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

  // Bits needed for a down-counter that can hold max_val; never narrower than 1.
  function automatic int timer_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/spi_tx_sequencer_if.sv
// rtl/spi_tx_sequencer_if.sv - frame request/completion handshake towards the SPI master
interface spi_tx_sequencer_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_done;

  modport master (output tx_data, output tx_valid, input tx_ready, input tx_done);
  modport slave  (input tx_data, input tx_valid, output tx_ready, output tx_done);
endinterface

// File: rtl/spi_tx_sequencer_cycle_timer.sv
// rtl/spi_tx_sequencer_cycle_timer.sv - loadable down-counter with clear, enable and expired flag
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_100,
  input  logic         a_rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats load beats decrement; the count rests at zero once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);
endmodule

// File: rtl/spi_tx_sequencer.sv
// rtl/spi_tx_sequencer.sv - button-driven SPI frame sequencer with pending slot, gap and timeout
module spi_tx_sequencer
  import spi_ctrl_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int COUNT_MAX      = DEF_COUNT_MAX,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk_100,
  input  logic                a_rst,
  input  logic                s_rst,
  input  logic                next_count_i,
  input  logic                start_send_i,
  spi_tx_sequencer_if.master  tx_if,
  output logic [DATA_W-1:0]   count_o,
  output logic                busy_o,
  output logic                pending_o,
  output logic                overrun_o,
  output logic                timeout_o
);
  localparam int TO_W  = timer_w(TIMEOUT_CYCLES);
  localparam int GAP_W = timer_w(GAP_CYCLES);
  localparam logic [TO_W-1:0]   TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DATA_W-1:0] CNT_MAX  = DATA_W'(COUNT_MAX);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic              dispatch;
  logic              to_load, to_expired;
  logic              gap_load, gap_expired;

  // Timeout timer runs only in WAIT_DONE; expired on the TIMEOUT_CYCLES-th cycle there.
  cycle_timer #(.W(TO_W)) u_timeout (
    .clk_100   (clk_100),
    .a_rst     (a_rst),
    .clr_i     (s_rst),
    .load_i    (to_load),
    .load_val_i(TO_LOAD),
    .en_i      (state_q == ST_WAIT_DONE),
    .expired_o (to_expired)
  );

  // Gap timer runs only in GAP; expired on the last gap cycle.
  cycle_timer #(.W(GAP_W)) u_gap (
    .clk_100   (clk_100),
    .a_rst     (a_rst),
    .clr_i     (s_rst),
    .load_i    (gap_load),
    .load_val_i(GAP_LOAD),
    .en_i      (state_q == ST_GAP),
    .expired_o (gap_expired)
  );

  // Next state, payload counter, frame latch and request queue.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    pending_d = pending_q;
    overrun_d = 1'b0;
    dispatch  = 1'b0;
    to_load   = 1'b0;
    gap_load  = 1'b0;
    count_d   = count_q;
    if (next_count_i) begin
      count_d = (count_q == CNT_MAX) ? '0 : count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_send_i) begin
          data_d  = count_q;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tx_if.tx_ready) begin
          state_d = ST_WAIT_DONE;
          to_load = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_if.tx_done || to_expired) begin
          if (GAP_CYCLES == 0) begin
            dispatch = 1'b1;
          end else begin
            state_d  = ST_GAP;
            gap_load = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_expired) begin
          dispatch = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // At the end of a frame a held request (or one arriving right now) is launched directly.
    if (state_q != ST_IDLE) begin
      if (dispatch) begin
        if (pending_q || start_send_i) begin
          data_d    = count_q;
          state_d   = ST_REQ;
          pending_d = pending_q && start_send_i;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (start_send_i) begin
        if (pending_q) begin
          overrun_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end
    end

    if (s_rst) begin
      state_d   = ST_IDLE;
      count_d   = '0;
      data_d    = '0;
      pending_d = 1'b0;
      overrun_d = 1'b0;
    end

    valid_d = (state_d == ST_REQ);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_100 or posedge a_rst) begin
    if (a_rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign tx_if.tx_data  = data_q;
  assign tx_if.tx_valid = valid_q;
  assign count_o        = count_q;
  assign busy_o         = busy_q;
  assign pending_o      = pending_q;
  assign overrun_o      = overrun_q;
  // A completion arriving in the expiry cycle suppresses the abort.
  assign timeout_o      = (state_q == ST_WAIT_DONE) && to_expired && !tx_if.tx_done;
endmodule

// File: tb/tb_spi_tx_sequencer.sv
// tb/tb_spi_tx_sequencer.sv - self-checking bench for spi_tx_sequencer
module tb_spi_tx_sequencer;
  localparam int CMAX  = 255;
  localparam int GAP_A = 100;
  localparam int TO_A  = 16;
  localparam int TO_B  = 16;

  logic       clk_100 = 1'b0;
  logic       a_rst, s_rst;
  logic       nc_a, ss_a, nc_b, ss_b;
  logic [7:0] cnt_a, cnt_b;
  logic       busy_a, pend_a, ovr_a, to_a;
  logic       busy_b, pend_b, ovr_b, to_b;
  int         total = 0;
  int         bad = 0;
  int         mcount_a = 0;
  int         mcount_b = 0;

  spi_tx_sequencer_if #(.DATA_W(8)) if_a ();
  spi_tx_sequencer_if #(.DATA_W(8)) if_b ();

  always #5 clk_100 = ~clk_100;

  spi_tx_sequencer #(.DATA_W(8), .COUNT_MAX(CMAX), .GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A)) dut_a (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst),
    .next_count_i(nc_a), .start_send_i(ss_a), .tx_if(if_a),
    .count_o(cnt_a), .busy_o(busy_a), .pending_o(pend_a), .overrun_o(ovr_a), .timeout_o(to_a)
  );

  spi_tx_sequencer #(.DATA_W(8), .COUNT_MAX(CMAX), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_B)) dut_b (
    .clk_100(clk_100), .a_rst(a_rst), .s_rst(s_rst),
    .next_count_i(nc_b), .start_send_i(ss_b), .tx_if(if_b),
    .count_o(cnt_b), .busy_o(busy_b), .pending_o(pend_b), .overrun_o(ovr_b), .timeout_o(to_b)
  );

  task automatic cyc();
    @(negedge clk_100);
  endtask

  task automatic pulse_nc_a(input int n);
    for (int i = 0; i < n; i++) begin
      nc_a = 1'b1;
      cyc();
      mcount_a = (mcount_a + 1) % (CMAX + 1);
    end
    nc_a = 1'b0;
  endtask

  task automatic pulse_nc_b(input int n);
    for (int i = 0; i < n; i++) begin
      nc_b = 1'b1;
      cyc();
      mcount_b = (mcount_b + 1) % (CMAX + 1);
    end
    nc_b = 1'b0;
  endtask

  task automatic wait_idle_a(output int n);
    n = 0;
    while (busy_a && n < 500) begin
      cyc();
      n++;
    end
  endtask

  task automatic frame_a();
    int n;
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    if_a.tx_done = 1'b1; cyc(); if_a.tx_done = 1'b0;
    wait_idle_a(n);
    total++;
    if (busy_a !== 1'b0) begin bad++; $display("FAIL frame_idle busy=%0b exp=0 after %0d cycles", busy_a, n); end
  endtask

  task automatic test_reset();
    @(negedge clk_100);
    total++;
    if ({cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs_a got=%h exp=0", {cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a});
    end
    total++;
    if ({cnt_b, if_b.tx_valid, busy_b, pend_b} !== 11'd0) begin
      bad++; $display("FAIL reset_outputs_b got=%h exp=0", {cnt_b, if_b.tx_valid, busy_b, pend_b});
    end
    a_rst = 1'b0;
  endtask

  task automatic test_counter();
    int n;
    pulse_nc_a(3);
    total++;
    if (cnt_a !== 8'(mcount_a)) begin bad++; $display("FAIL count3 got=%0d exp=%0d", cnt_a, mcount_a); end
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    total++;
    if ({if_a.tx_valid, if_a.tx_data, busy_a} !== {1'b1, 8'd3, 1'b1}) begin
      bad++; $display("FAIL launch valid=%0b data=%0d busy=%0b exp 1/3/1", if_a.tx_valid, if_a.tx_data, busy_a);
    end
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if ({if_a.tx_valid, if_a.tx_data} !== {1'b1, 8'd3}) begin
        bad++; $display("FAIL stall_hold valid=%0b data=%0d exp 1/3", if_a.tx_valid, if_a.tx_data);
      end
    end
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    total++;
    if ({if_a.tx_valid, busy_a} !== 2'b01) begin
      bad++; $display("FAIL wait_done valid=%0b busy=%0b exp 0/1", if_a.tx_valid, busy_a);
    end
    if_a.tx_done = 1'b1; cyc(); if_a.tx_done = 1'b0;
    wait_idle_a(n);
    total++;
    if (n !== GAP_A) begin bad++; $display("FAIL gap_length got=%0d exp=%0d", n, GAP_A); end
  endtask

  task automatic test_wrap();
    int exp_data;
    pulse_nc_a(CMAX - mcount_a);
    total++;
    if (cnt_a !== 8'(CMAX)) begin bad++; $display("FAIL count_max got=%0d exp=%0d", cnt_a, CMAX); end
    pulse_nc_a(1);
    total++;
    if (cnt_a !== 8'(mcount_a) || mcount_a != 0) begin bad++; $display("FAIL count_wrap got=%0d exp=0", cnt_a); end
    pulse_nc_a(7);
    exp_data = mcount_a;
    nc_a = 1'b1; ss_a = 1'b1; cyc(); nc_a = 1'b0; ss_a = 1'b0;
    mcount_a = (mcount_a + 1) % (CMAX + 1);
    total++;
    if ({if_a.tx_valid, if_a.tx_data, cnt_a} !== {1'b1, 8'(exp_data), 8'(mcount_a)}) begin
      bad++; $display("FAIL same_cycle valid=%0b data=%0d count=%0d exp 1/%0d/%0d", if_a.tx_valid, if_a.tx_data, cnt_a, exp_data, mcount_a);
    end
    frame_a();
  endtask

  task automatic test_queuing();
    int n;
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    total++;
    if ({pend_a, ovr_a} !== 2'b10) begin bad++; $display("FAIL pending_set pend=%0b ovr=%0b exp 1/0", pend_a, ovr_a); end
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    total++;
    if ({pend_a, ovr_a} !== 2'b11) begin bad++; $display("FAIL overrun pend=%0b ovr=%0b exp 1/1", pend_a, ovr_a); end
    cyc();
    total++;
    if ({pend_a, ovr_a} !== 2'b10) begin bad++; $display("FAIL overrun_pulse pend=%0b ovr=%0b exp 1/0", pend_a, ovr_a); end
    pulse_nc_a(2);
    if_a.tx_done = 1'b1; cyc(); if_a.tx_done = 1'b0;
    pulse_nc_a(3);
    n = 3;
    while (!if_a.tx_valid && n < 500) begin cyc(); n++; end
    total++;
    if (n !== GAP_A) begin bad++; $display("FAIL reissue_delay got=%0d exp=%0d", n, GAP_A); end
    total++;
    if ({if_a.tx_data, pend_a} !== {8'(mcount_a), 1'b0}) begin
      bad++; $display("FAIL reissue_data data=%0d pend=%0b exp %0d/0", if_a.tx_data, pend_a, mcount_a);
    end
    frame_a();
  endtask

  task automatic test_timeout();
    int k;
    logic seen;
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    k = 1;
    while (!to_a && k < 100) begin cyc(); k++; end
    total++;
    if (k !== TO_A) begin bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", k, TO_A); end
    cyc();
    total++;
    if ({to_a, busy_a, if_a.tx_valid} !== 3'b010) begin
      bad++; $display("FAIL timeout_to_gap to=%0b busy=%0b valid=%0b exp 0/1/0", to_a, busy_a, if_a.tx_valid);
    end
    wait_idle_a(k);
    total++;
    if (k !== GAP_A) begin bad++; $display("FAIL timeout_gap got=%0d exp=%0d", k, GAP_A); end
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    seen = 1'b0;
    for (int i = 1; i < TO_A; i++) begin
      if (to_a) seen = 1'b1;
      cyc();
    end
    if_a.tx_done = 1'b1;
    #1;
    total++;
    if ({seen, to_a} !== 2'b00) begin bad++; $display("FAIL done_wins seen=%0b to=%0b exp 0/0", seen, to_a); end
    cyc(); if_a.tx_done = 1'b0;
    total++;
    if ({to_a, busy_a} !== 2'b01) begin bad++; $display("FAIL done_to_gap to=%0b busy=%0b exp 0/1", to_a, busy_a); end
    wait_idle_a(k);
  endtask

  task automatic test_gap0();
    int exp_data;
    pulse_nc_b(5);
    ss_b = 1'b1; cyc(); ss_b = 1'b0;
    total++;
    if ({if_b.tx_valid, if_b.tx_data} !== {1'b1, 8'(mcount_b)}) begin
      bad++; $display("FAIL gap0_launch valid=%0b data=%0d exp 1/%0d", if_b.tx_valid, if_b.tx_data, mcount_b);
    end
    if_b.tx_ready = 1'b1; cyc(); if_b.tx_ready = 1'b0;
    ss_b = 1'b1; cyc(); ss_b = 1'b0;
    exp_data = mcount_b;
    if_b.tx_done = 1'b1; nc_b = 1'b1; cyc(); if_b.tx_done = 1'b0; nc_b = 1'b0;
    mcount_b = (mcount_b + 1) % (CMAX + 1);
    total++;
    if ({if_b.tx_valid, if_b.tx_data, pend_b, busy_b} !== {1'b1, 8'(exp_data), 1'b0, 1'b1}) begin
      bad++; $display("FAIL gap0_reissue valid=%0b data=%0d pend=%0b busy=%0b exp 1/%0d/0/1", if_b.tx_valid, if_b.tx_data, pend_b, busy_b, exp_data);
    end
    if_b.tx_ready = 1'b1; cyc(); if_b.tx_ready = 1'b0;
    if_b.tx_done = 1'b1; cyc(); if_b.tx_done = 1'b0;
    total++;
    if ({busy_b, if_b.tx_valid} !== 2'b00) begin bad++; $display("FAIL gap0_idle busy=%0b valid=%0b exp 0/0", busy_b, if_b.tx_valid); end
  endtask

  task automatic test_random();
    int   starts = 0, hs = 0, ovr_cnt = 0, prev_cnt;
    logic prev_valid;
    logic [7:0] prev_data;
    logic drain;
    for (int c = 0; c < 2300; c++) begin
      drain = (c >= 2000);
      nc_b = !drain && ($urandom_range(0, 1) == 1);
      ss_b = !drain && ($urandom_range(0, 4) == 0);
      if_b.tx_ready = drain || ($urandom_range(0, 1) == 1);
      if_b.tx_done = ($urandom_range(0, 3) == 0);
      if (ss_b) starts++;
      if (if_b.tx_valid && if_b.tx_ready) hs++;
      prev_cnt = mcount_b;
      prev_valid = if_b.tx_valid;
      prev_data = if_b.tx_data;
      if (nc_b) mcount_b = (mcount_b + 1) % (CMAX + 1);
      cyc();
      if (ovr_b) ovr_cnt++;
      total++;
      if (cnt_b !== 8'(mcount_b)) begin bad++; $display("FAIL rnd_count cycle=%0d got=%0d exp=%0d", c, cnt_b, mcount_b); end
      if (if_b.tx_valid && !prev_valid) begin
        total++;
        if (if_b.tx_data !== 8'(prev_cnt)) begin bad++; $display("FAIL rnd_latch cycle=%0d got=%0d exp=%0d", c, if_b.tx_data, prev_cnt); end
      end else if (if_b.tx_valid && prev_valid) begin
        total++;
        if (if_b.tx_data !== prev_data) begin bad++; $display("FAIL rnd_stable cycle=%0d got=%0d exp=%0d", c, if_b.tx_data, prev_data); end
      end
    end
    nc_b = 1'b0; ss_b = 1'b0; if_b.tx_ready = 1'b0; if_b.tx_done = 1'b0;
    total++;
    if ({busy_b, pend_b, to_b} !== 3'b000) begin bad++; $display("FAIL rnd_drain busy=%0b pend=%0b to=%0b exp 0/0/0", busy_b, pend_b, to_b); end
    total++;
    if (starts !== hs + ovr_cnt) begin bad++; $display("FAIL rnd_conserve starts=%0d exp handshakes+overruns=%0d", starts, hs + ovr_cnt); end
  endtask

  task automatic test_resets();
    pulse_nc_a(2);
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    a_rst = 1'b1;
    #1;
    total++;
    if ({cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a} !== 21'd0) begin
      bad++; $display("FAIL arst_req got=%h exp=0", {cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a});
    end
    mcount_a = 0; mcount_b = 0;
    cyc(); a_rst = 1'b0;
    pulse_nc_a(4);
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    if_a.tx_ready = 1'b1; cyc(); if_a.tx_ready = 1'b0;
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    if_a.tx_done = 1'b1; cyc(); if_a.tx_done = 1'b0;
    total++;
    if ({busy_a, pend_a} !== 2'b11) begin bad++; $display("FAIL gap_pending busy=%0b pend=%0b exp 1/1", busy_a, pend_a); end
    a_rst = 1'b1;
    #1;
    total++;
    if ({cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a} !== 21'd0) begin
      bad++; $display("FAIL arst_gap got=%h exp=0", {cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a});
    end
    mcount_a = 0;
    cyc(); a_rst = 1'b0;
    pulse_nc_a(3);
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    s_rst = 1'b1;
    #1;
    total++;
    if ({if_a.tx_valid, busy_a, cnt_a} !== {1'b1, 1'b1, 8'(mcount_a)}) begin
      bad++; $display("FAIL srst_before_edge valid=%0b busy=%0b count=%0d exp 1/1/%0d", if_a.tx_valid, busy_a, cnt_a, mcount_a);
    end
    cyc(); s_rst = 1'b0;
    mcount_a = 0; mcount_b = 0;
    total++;
    if ({cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a} !== 21'd0) begin
      bad++; $display("FAIL srst got=%h exp=0", {cnt_a, if_a.tx_data, if_a.tx_valid, busy_a, pend_a, ovr_a, to_a});
    end
    ss_a = 1'b1; cyc(); ss_a = 1'b0;
    total++;
    if ({if_a.tx_valid, if_a.tx_data} !== {1'b1, 8'd0}) begin
      bad++; $display("FAIL post_reset_send valid=%0b data=%0d exp 1/0", if_a.tx_valid, if_a.tx_data);
    end
    frame_a();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; s_rst = 1'b0;
    nc_a = 1'b0; ss_a = 1'b0; nc_b = 1'b0; ss_b = 1'b0;
    if_a.tx_ready = 1'b0; if_a.tx_done = 1'b0;
    if_b.tx_ready = 1'b0; if_b.tx_done = 1'b0;
    test_reset();
    test_counter();
    test_wrap();
    test_queuing();
    test_timeout();
    test_gap0();
    test_random();
    test_resets();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_tx_sequencer.md
Name: spi_tx_sequencer

Overview:
- Sequences SPI master transmissions from the debounced, edge-detected button pulses (next_count, start_send).
- Keeps the payload counter, latches a frame word on each send request and launches it to the SPI master over a valid/ready handshake.
- Waits for frame completion (with timeout), enforces an inter-frame gap and holds one pending request.
- Sits between the button handler and the SPI master core in the clk_100 domain.

Parameters:
- DATA_W, 8, SPI frame / payload counter width.
- COUNT_MAX, 255, last payload value before wrap to 0; must be < 2**DATA_W.
- GAP_CYCLES, 100, idle clk_100 cycles between frames; 0 = no gap.
- TIMEOUT_CYCLES, 4096, max cycles in WAIT_DONE before abort; must be >= 1.

Ports:
- clk_100  in  1  system clock, 100 MHz.
- a_rst  in  1  reset, asynchronous, active-high.
- s_rst  in  1  synchronous reset, active-high; same effect as a_rst.
- next_count_i  in  1  single-cycle pulse: increment payload counter.
- start_send_i  in  1  single-cycle pulse: request a frame.
- tx_data_o  out  DATA_W  frame word to SPI master.
- tx_valid_o  out  1  frame request valid.
- tx_ready_i  in  1  SPI master accepts the request when valid && ready.
- tx_done_i  in  1  single-cycle pulse: frame shifted out.
- count_o  out  DATA_W  current payload counter.
- busy_o  out  1  high in any state except IDLE.
- pending_o  out  1  one queued request held.
- overrun_o  out  1  1-cycle pulse: request dropped.
- timeout_o  out  1  1-cycle pulse: frame aborted on timeout.

Behaviour:
- Reset, a_rst or s_rst:
  - State goes to IDLE.
  - count_o, tx_data_o, tx_valid_o, pending_o, overrun_o, timeout_o, busy_o all 0.
  - Gap and timeout timers cleared.
  - A reset mid-frame drops the frame and the pending request without warning.
- Payload counter:
  - next_count_i increments count_o in every state.
  - COUNT_MAX is followed by 0.
  - Never affects a word already latched in tx_data_o.
- States:
  - IDLE: start_send_i at cycle N latches count_o as it was at cycle N (the pre-increment value if next_count_i coincides) into tx_data_o; state is REQ at N+1.
  - REQ: tx_valid_o = 1. tx_data_o stays stable until the handshake. On tx_valid_o && tx_ready_i, valid drops the next cycle and the state goes to WAIT_DONE with the timeout timer cleared.
  - WAIT_DONE: tx_done_i goes to GAP, or to IDLE if GAP_CYCLES = 0. If the timer reaches TIMEOUT_CYCLES without tx_done_i, timeout_o pulses and the state goes to GAP / IDLE as above. tx_done_i in the expiry cycle wins, with no timeout pulse.
  - GAP: counts GAP_CYCLES cycles. On the last cycle: if pending_o, clear it, latch the current count_o into tx_data_o and go directly to REQ; else go to IDLE.
  - The IDLE exit with GAP_CYCLES = 0 also services pending_o the same way.
- tx_done_i outside WAIT_DONE is ignored.
- Request queuing:
  - start_send_i while busy_o with pending_o = 0 sets pending_o.
  - start_send_i while pending_o = 1 pulses overrun_o; the request is dropped and pending_o stays 1.
  - start_send_i in the same cycle pending_o is consumed sets pending_o again; no overrun.
- Timing:
  - busy_o is registered, reflecting the state.
  - Minimum frame-to-frame spacing is handshake + done + GAP_CYCLES.

Decomposition:
- spi_ctrl_pkg:
  - State enum: IDLE, REQ, WAIT_DONE, GAP.
  - Default DATA_W, COUNT_MAX, GAP_CYCLES, TIMEOUT_CYCLES constants.
  - Function clog2-based timer width.
- Sub-module cycle_timer:
  - Loadable down-counter with clr, en and expired output.
  - Instantiated twice: gap and timeout.

Test Plan:
- Reset counter: 3 next_count_i pulses, then start_send_i -> tx_valid_o the next cycle with tx_data_o = 3; ready held 0 for 5 cycles -> valid and data stable; ready = 1 -> WAIT_DONE, busy_o = 1.
- Wrap: COUNT_MAX = 255, 256 next_count_i pulses -> count_o = 0. next_count_i and start_send_i in the same IDLE cycle at count 7 -> tx_data_o = 7, count_o = 8.
- Queuing: start during WAIT_DONE -> pending_o = 1; a second start -> overrun_o 1-cycle pulse. tx_done_i + 100 gap cycles -> REQ with the then-current count, pending_o = 0.
- Timeout: TIMEOUT_CYCLES = 16, no tx_done_i -> timeout_o pulses 16 cycles after the handshake, then GAP, then IDLE. tx_done_i on cycle 16 -> no timeout_o.
- GAP_CYCLES = 0: tx_done_i -> IDLE next cycle; a pending request reissues with no idle gap.
- Resets: a_rst asserted in REQ and in GAP with pending -> all outputs 0 immediately, without a clock. s_rst does the same at the next edge. A post-reset start_send_i sends 0.
